layer_compositor: RTL and testbench
===================================

LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 SHALL have parameter N_OBJ, default 6, number of drawable objects (2..16); index 0 is highest priority.
REQ-002 SHALL have parameter COORD_W, default 10, pixel coordinate width.
REQ-003 SHALL have parameter FLASH_PERIOD, default 16, frames per flash half-cycle (>=1).
REQ-004 SHALL have parameter BG_COLOR, default 24'h70707F, active-area background {R,G,B}.
REQ-005 SHALL have port Clk, input, 1, pixel clock.
REQ-006 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port pix_ce, input, 1, pixel strobe; the pipeline advances only when it is 1.
REQ-008 SHALL have port frame_start, input, 1, one-cycle pulse at frame start (independent of pix_ce).
REQ-009 SHALL have ports DrawX and DrawY, input, COORD_W each, current pixel.
REQ-010 SHALL have port blank, input, 1, 1 = active video.
REQ-011 SHALL have ports ObjX and ObjY, input, N_OBJ*COORD_W each, object centres.
REQ-012 SHALL have ports ObjHalfW and ObjHalfH, input, N_OBJ*COORD_W each, half extents; a circle uses ObjHalfW as its radius.
REQ-013 SHALL have port ObjShape, input, N_OBJ, 0 = rectangle, 1 = circle.
REQ-014 SHALL have port ObjEn, input, N_OBJ, object enable.
REQ-015 SHALL have port ObjFlash, input, N_OBJ, flash-mode enable.
REQ-016 SHALL have port ObjColor, input, N_OBJ*24, per-object {R,G,B}.
REQ-017 SHALL have ports Red, Green and Blue, output, 8 each, registered pixel colour.
REQ-018 SHALL have port CollideMask, output, N_OBJ, collision snapshot of the previous frame.

Function
REQ-019 SHALL implement a 3-stage pipeline with latency 3 pix_ce strobes from DrawX/DrawY/blank to Red/Green/Blue; all stages hold their state when pix_ce is 0.
REQ-020 SHALL, in stage 1, register dx = DrawX - ObjX and dy = DrawY - ObjY per object as signed COORD_W+1 values; there is no unsigned wrap.
REQ-021 SHALL, in stage 2, register hit[i]: rectangle when |dx| <= HalfW and |dy| <= HalfH; circle when dx*dx + dy*dy <= HalfW*HalfW, computed at 2*COORD_W+2 bits unsigned.
REQ-022 SHALL force hit[i] to 0 when ObjEn[i] is 0.
REQ-023 SHALL define vis[i] = hit[i] AND NOT (ObjFlash[i] AND flash_phase).
REQ-024 SHALL, in stage 3, output ObjColor of the lowest index with vis set; otherwise BG_COLOR if delayed blank is 1, else 0.
REQ-025 SHALL output black whenever delayed blank is 0, even if an object hit is present.
REQ-026 SHALL OR hit[i] (not vis[i]) into collide_acc[i] for all i in stage 3 when two or more hit bits are set on a pix_ce cycle.
REQ-027 SHALL, on frame_start, load CollideMask with collide_acc OR the same-cycle stage-3 contribution, then clear collide_acc.
REQ-028 SHALL maintain frame_cnt (0..FLASH_PERIOD-1), incremented on frame_start; at wrap it returns to 0 and toggles flash_phase.
REQ-029 SHALL apply ObjX..ObjColor combinationally per stage without capture; callers change them only during vertical blank.

Reset
REQ-030 SHALL clear on Reset_n = 0 (asynchronous): pipeline registers, Red/Green/Blue = 0, CollideMask = 0, collide_acc = 0, frame_cnt = 0, flash_phase = 0.
REQ-031 SHALL release deasserting reset synchronously to Clk; the first valid pixel appears 3 pix_ce strobes later, with prior outputs 0.

Structure
REQ-032 SHALL place in the package compositor_pkg: the shape enum (SHAPE_RECT, SHAPE_CIRCLE), the rgb24 struct, and the default BG_COLOR constant.
REQ-033 SHALL implement the stage-1/stage-2 per-object hit test in sub-module obj_hit_test, instantiated N_OBJ times via generate.
REQ-034 SHALL keep priority, collision and flash logic in layer_compositor.

Verification
REQ-035 SHALL cover: obj0 rect at (100,100) half (10,10) red, pix_ce = 1, DrawX = 110, DrawY = 90 -> FF0000 after 3 strobes; DrawX = 111 -> 70707F.
REQ-036 SHALL cover: obj1 circle at (5,5) radius 8, DrawX = 0, DrawY = 0 -> obj1 colour, with no wrap; DrawX = 0, DrawY = 12 -> background.
REQ-037 SHALL cover: obj0 and obj2 overlapping at (200,200), pixel swept through the overlap -> obj0 colour; CollideMask = 000101 after next frame_start and 000000 after the following frame_start with no overlap.
REQ-038 SHALL cover: ObjFlash[0] = 1, FLASH_PERIOD = 2 -> obj0 visible frames 0-1, hidden 2-3 while CollideMask still reports overlaps.
REQ-039 SHALL cover: pix_ce toggling 1,0,0,1 -> output changes only on strobes; blank = 0 over an object -> 000000.
REQ-040 SHALL cover: Reset_n pulsed low mid-frame with a collision pending -> all outputs 0 immediately, CollideMask 0 after next frame_start.

Source files
------------

// File: rtl/compositor_pkg.sv
// Shared types and constants for the layer compositor.
package compositor_pkg;

  typedef enum logic {
    SHAPE_RECT   = 1'b0,
    SHAPE_CIRCLE = 1'b1
  } shape_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  localparam logic [23:0] BG_COLOR_DEFAULT = 24'h70707F;

endpackage

// File: rtl/obj_hit_test.sv
// Per-object hit test: stage 1 registers signed offsets, stage 2 registers the hit bit.
module obj_hit_test
  import compositor_pkg::*;
#(
  parameter int unsigned CoordW = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pix_ce_i,
  input  logic [CoordW-1:0] draw_x_i,
  input  logic [CoordW-1:0] draw_y_i,
  input  logic [CoordW-1:0] obj_x_i,
  input  logic [CoordW-1:0] obj_y_i,
  input  logic [CoordW-1:0] half_w_i,
  input  logic [CoordW-1:0] half_h_i,
  input  shape_e            shape_i,
  input  logic              en_i,
  output logic              hit_o
);

  localparam int unsigned SqW = 2 * CoordW + 2;

  logic signed [CoordW:0] dx_d, dx_q, dy_d, dy_q;
  logic        [CoordW:0] adx, ady;
  logic        [SqW-1:0]  dist2, rad2;
  logic                   in_shape;
  logic                   hit_d, hit_q;

  // Offsets carry an extra sign bit so negative distances never wrap.
  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (pix_ce_i) begin
      dx_d = $signed({1'b0, draw_x_i}) - $signed({1'b0, obj_x_i});
      dy_d = $signed({1'b0, draw_y_i}) - $signed({1'b0, obj_y_i});
    end
  end

  always_comb begin
    adx   = dx_q[CoordW] ? $unsigned(-dx_q) : $unsigned(dx_q);
    ady   = dy_q[CoordW] ? $unsigned(-dy_q) : $unsigned(dy_q);
    dist2 = SqW'(adx) * SqW'(adx) + SqW'(ady) * SqW'(ady);
    rad2  = SqW'(half_w_i) * SqW'(half_w_i);
    if (shape_i == SHAPE_CIRCLE) begin
      in_shape = (dist2 <= rad2);
    end else begin
      in_shape = (adx <= {1'b0, half_w_i}) && (ady <= {1'b0, half_h_i});
    end
    hit_d = pix_ce_i ? (en_i && in_shape) : hit_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dx_q  <= '0;
      dy_q  <= '0;
      hit_q <= 1'b0;
    end else begin
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      hit_q <= hit_d;
    end
  end

  assign hit_o = hit_q;

endmodule

// File: rtl/layer_compositor.sv
// Three-stage sprite compositor: per-object hit test, priority colour select,
// per-frame collision snapshot and flash phase generation.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int unsigned N_OBJ        = 6,
  parameter int unsigned COORD_W      = 10,
  parameter int unsigned FLASH_PERIOD = 16,
  parameter logic [23:0] BG_COLOR     = BG_COLOR_DEFAULT
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      pix_ce,
  input  logic                      frame_start,
  input  logic [COORD_W-1:0]        DrawX,
  input  logic [COORD_W-1:0]        DrawY,
  input  logic                      blank,
  input  logic [N_OBJ*COORD_W-1:0]  ObjX,
  input  logic [N_OBJ*COORD_W-1:0]  ObjY,
  input  logic [N_OBJ*COORD_W-1:0]  ObjHalfW,
  input  logic [N_OBJ*COORD_W-1:0]  ObjHalfH,
  input  logic [N_OBJ-1:0]          ObjShape,
  input  logic [N_OBJ-1:0]          ObjEn,
  input  logic [N_OBJ-1:0]          ObjFlash,
  input  logic [N_OBJ*24-1:0]       ObjColor,
  output logic [7:0]                Red,
  output logic [7:0]                Green,
  output logic [7:0]                Blue,
  output logic [N_OBJ-1:0]          CollideMask
);

  localparam int unsigned CntW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;

  logic [N_OBJ-1:0] hit, vis, contrib;
  logic             multi_hit;
  logic             blank_s1_d, blank_s1_q, blank_s2_d, blank_s2_q;
  rgb24_t           pix_color, rgb_d, rgb_q;
  logic [N_OBJ-1:0] collide_acc_d, collide_acc_q, collide_mask_d, collide_mask_q;
  logic [CntW-1:0]  frame_cnt_d, frame_cnt_q;
  logic             flash_phase_d, flash_phase_q;

  for (genvar g = 0; g < N_OBJ; g++) begin : g_obj
    obj_hit_test #(
      .CoordW (COORD_W)
    ) u_hit (
      .clk_i    (Clk),
      .rst_ni   (Reset_n),
      .pix_ce_i (pix_ce),
      .draw_x_i (DrawX),
      .draw_y_i (DrawY),
      .obj_x_i  (ObjX[g*COORD_W +: COORD_W]),
      .obj_y_i  (ObjY[g*COORD_W +: COORD_W]),
      .half_w_i (ObjHalfW[g*COORD_W +: COORD_W]),
      .half_h_i (ObjHalfH[g*COORD_W +: COORD_W]),
      .shape_i  (shape_e'(ObjShape[g])),
      .en_i     (ObjEn[g]),
      .hit_o    (hit[g])
    );
  end

  always_comb begin
    blank_s1_d = pix_ce ? blank      : blank_s1_q;
    blank_s2_d = pix_ce ? blank_s1_q : blank_s2_q;
  end

  // Scan from lowest priority upward so index 0 wins.
  always_comb begin
    vis       = hit & ~(ObjFlash & {N_OBJ{flash_phase_q}});
    pix_color = BG_COLOR;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (vis[i]) pix_color = ObjColor[i*24 +: 24];
    end
    if (!blank_s2_q) pix_color = '0;
    rgb_d = pix_ce ? pix_color : rgb_q;
  end

  // Collisions use raw hits so flashing objects still report overlaps.
  always_comb begin
    multi_hit      = (int'($countones(hit)) >= 2);
    contrib        = (pix_ce && multi_hit) ? hit : '0;
    collide_acc_d  = frame_start ? '0 : (collide_acc_q | contrib);
    collide_mask_d = frame_start ? (collide_acc_q | contrib) : collide_mask_q;
  end

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    flash_phase_d = flash_phase_q;
    if (frame_start) begin
      if (frame_cnt_q == CntW'(FLASH_PERIOD - 1)) begin
        frame_cnt_d   = '0;
        flash_phase_d = ~flash_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      blank_s1_q     <= 1'b0;
      blank_s2_q     <= 1'b0;
      rgb_q          <= '0;
      collide_acc_q  <= '0;
      collide_mask_q <= '0;
      frame_cnt_q    <= '0;
      flash_phase_q  <= 1'b0;
    end else begin
      blank_s1_q     <= blank_s1_d;
      blank_s2_q     <= blank_s2_d;
      rgb_q          <= rgb_d;
      collide_acc_q  <= collide_acc_d;
      collide_mask_q <= collide_mask_d;
      frame_cnt_q    <= frame_cnt_d;
      flash_phase_q  <= flash_phase_d;
    end
  end

  assign Red         = rgb_q.r;
  assign Green       = rgb_q.g;
  assign Blue        = rgb_q.b;
  assign CollideMask = collide_mask_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor with a geometric reference model.
module tb_layer_compositor;

  localparam int N  = 6;
  localparam int W  = 10;
  localparam int FP = 2;
  localparam logic [23:0] BG = 24'h70707F;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b0;
  logic             pix_ce = 1'b0;
  logic             frame_start = 1'b0;
  logic [W-1:0]     DrawX = '0;
  logic [W-1:0]     DrawY = '0;
  logic             blank = 1'b0;
  logic [N*W-1:0]   ObjX, ObjY, ObjHalfW, ObjHalfH;
  logic [N-1:0]     ObjShape, ObjEn, ObjFlash;
  logic [N*24-1:0]  ObjColor;
  logic [7:0]       Red, Green, Blue;
  logic [N-1:0]     CollideMask;

  int          ox[N], oy[N], hw[N], hh[N];
  bit          shp[N], en[N], fl[N];
  logic [23:0] col[N];

  for (genvar g = 0; g < N; g++) begin : g_cfg
    assign ObjX[g*W +: W]     = W'(ox[g]);
    assign ObjY[g*W +: W]     = W'(oy[g]);
    assign ObjHalfW[g*W +: W] = W'(hw[g]);
    assign ObjHalfH[g*W +: W] = W'(hh[g]);
    assign ObjShape[g]        = shp[g];
    assign ObjEn[g]           = en[g];
    assign ObjFlash[g]        = fl[g];
    assign ObjColor[g*24 +: 24] = col[g];
  end

  layer_compositor #(
    .N_OBJ        (N),
    .COORD_W      (W),
    .FLASH_PERIOD (FP),
    .BG_COLOR     (BG)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .pix_ce      (pix_ce),
    .frame_start (frame_start),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .ObjX        (ObjX),
    .ObjY        (ObjY),
    .ObjHalfW    (ObjHalfW),
    .ObjHalfH    (ObjHalfH),
    .ObjShape    (ObjShape),
    .ObjEn       (ObjEn),
    .ObjFlash    (ObjFlash),
    .ObjColor    (ObjColor),
    .Red         (Red),
    .Green       (Green),
    .Blue        (Blue),
    .CollideMask (CollideMask)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [N-1:0] hits;
    bit           b;
  } pe_t;

  pe_t          mp[$];     // pixels in flight, spaced by the 3-strobe latency
  logic [23:0]  exp_q[$];  // expected colours awaiting the monitor
  logic [N-1:0] acc, exp_mask;
  logic [23:0]  last_exp;
  int           frame_no;
  int           total = 0;
  int           bad = 0;

  wire [23:0] rgb = {Red, Green, Blue};

  task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_hits(input int x, input int y);
    logic [N-1:0] h;
    int dx, dy;
    h = '0;
    for (int i = 0; i < N; i++) begin
      dx = x - ox[i];
      dy = y - oy[i];
      if (en[i]) begin
        if (shp[i]) h[i] = (dx * dx + dy * dy) <= hw[i] * hw[i];
        else        h[i] = ((dx < 0) ? -dx : dx) <= hw[i] && ((dy < 0) ? -dy : dy) <= hh[i];
      end
    end
    return h;
  endfunction

  function automatic logic [23:0] model_color(input logic [N-1:0] h, input bit b);
    bit hidden_phase;
    if (!b) return 24'h0;
    hidden_phase = ((frame_no / FP) % 2) == 1;
    for (int i = 0; i < N; i++) begin
      if (h[i] && !(fl[i] && hidden_phase)) return col[i];
    end
    return BG;
  endfunction

  // Issue one pixel on a strobe; optionally pulse frame_start on the same edge.
  task automatic strobe(input int x, input int y, input bit b, input bit fs);
    pe_t ne, e;
    logic [N-1:0] contrib;
    DrawX = W'(x); DrawY = W'(y); blank = b; pix_ce = 1'b1; frame_start = fs;
    ne.hits = model_hits(x, y);
    ne.b    = b;
    mp.push_back(ne);
    e = mp.pop_front();
    exp_q.push_back(model_color(e.hits, e.b));
    contrib = ($countones(e.hits) >= 2) ? e.hits : '0;
    if (fs) begin
      exp_mask = acc | contrib;
      acc      = '0;
      frame_no++;
    end else begin
      acc = acc | contrib;
    end
    @(negedge Clk);
    pix_ce = 1'b0; frame_start = 1'b0;
    if (fs) check("collide_mask_fs_strobe", 24'(CollideMask), 24'(exp_mask));
  endtask

  task automatic fs_only();
    frame_start = 1'b1;
    exp_mask = acc;
    acc = '0;
    frame_no++;
    @(negedge Clk);
    frame_start = 1'b0;
    check("collide_mask", 24'(CollideMask), 24'(exp_mask));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Far off-screen blanked pixels: never hit, so config may change afterwards.
  task automatic flush();
    repeat (3) strobe(1023, 1023, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    pe_t z;
    z.hits = '0; z.b = 1'b0;
    Reset_n = 1'b0; pix_ce = 1'b0; frame_start = 1'b0;
    #1;
    check("reset_rgb", rgb, 24'h0);
    check("reset_mask", 24'(CollideMask), 24'h0);
    mp.delete(); exp_q.delete();
    mp.push_back(z); mp.push_back(z);
    acc = '0; exp_mask = '0; frame_no = 0; last_exp = '0;
    @(negedge Clk); @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic clear_objs();
    for (int i = 0; i < N; i++) begin
      ox[i] = 0; oy[i] = 0; hw[i] = 0; hh[i] = 0;
      shp[i] = 0; en[i] = 0; fl[i] = 0; col[i] = '0;
    end
  endtask

  task automatic set_obj(input int i, input int x, input int y, input int w, input int h,
                         input bit s, input logic [23:0] c);
    ox[i] = x; oy[i] = y; hw[i] = w; hh[i] = h; shp[i] = s; col[i] = c; en[i] = 1'b1;
  endtask

  // Monitor: every strobe pops one expected pixel; other cycles must hold.
  initial begin
    logic [23:0] e;
    forever begin
      @(posedge Clk);
      if (Reset_n) begin
        if (pix_ce) begin
          #1;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_underflow: got empty queue expected entry at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("pixel", rgb, e);
            last_exp = e;
          end
        end else begin
          #1;
          check("hold", rgb, last_exp);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_objs();
    @(negedge Clk);
    apply_reset();

    // Rectangle edge and background.
    set_obj(0, 100, 100, 10, 10, 1'b0, 24'hFF0000);
    strobe(110, 90, 1'b1, 1'b0);
    strobe(111, 90, 1'b1, 1'b0);
    strobe(100, 100, 1'b1, 1'b0);
    flush();

    // Circle near origin: negative offsets must not wrap.
    set_obj(1, 5, 5, 8, 8, 1'b1, 24'h00FF00);
    strobe(0, 0, 1'b1, 1'b0);
    strobe(0, 12, 1'b1, 1'b0);
    strobe(13, 5, 1'b1, 1'b0);
    strobe(14, 5, 1'b1, 1'b0);
    flush();

    // Overlap priority and collision snapshot.
    clear_objs();
    set_obj(0, 200, 200, 5, 5, 1'b0, 24'hFF0000);
    set_obj(2, 200, 200, 8, 8, 1'b0, 24'h0000FF);
    for (int x = 190; x <= 210; x++) strobe(x, 200, 1'b1, 1'b0);
    flush();
    fs_only();
    strobe(50, 50, 1'b1, 1'b0);
    strobe(196, 200, 1'b1, 1'b0);
    flush();
    fs_only();

    // Strobe gaps and blanking over an object.
    strobe(200, 200, 1'b1, 1'b0);
    idle(2);
    strobe(207, 200, 1'b1, 1'b0);
    idle(1);
    strobe(200, 200, 1'b0, 1'b0);
    idle(3);
    flush();

    // Flashing top object: visible frames 0-1, hidden 2-3.
    apply_reset();
    fl[0] = 1'b1;
    for (int f = 0; f < 4; f++) begin
      strobe(200, 200, 1'b1, 1'b0);
      strobe(203, 200, 1'b1, 1'b0);
      flush();
      fs_only();
    end
    // Overlap reaching stage 3 on the frame_start strobe itself.
    strobe(200, 200, 1'b1, 1'b0);
    strobe(1023, 1023, 1'b0, 1'b0);
    strobe(1023, 1023, 1'b0, 1'b1);
    flush();
    fl[0] = 1'b0;

    // Randomized configurations and pixels.
    for (int r = 0; r < 6; r++) begin
      flush();
      for (int i = 0; i < N; i++) begin
        set_obj(i, $urandom_range(0, 400), $urandom_range(0, 400), $urandom_range(10, 120),
                $urandom_range(10, 120), 1'($urandom_range(0, 1)), 24'($urandom));
        en[i] = ($urandom_range(0, 4) != 0);
        fl[i] = 1'($urandom_range(0, 1));
      end
      for (int p = 0; p < 120; p++) begin
        strobe($urandom_range(0, 500), $urandom_range(0, 500), ($urandom_range(0, 5) != 0),
               ($urandom_range(0, 15) == 0));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      flush();
      fs_only();
    end

    // Reset mid-frame with a collision pending.
    clear_objs();
    set_obj(0, 200, 200, 5, 5, 1'b0, 24'hFF0000);
    set_obj(2, 200, 200, 8, 8, 1'b0, 24'h0000FF);
    strobe(200, 200, 1'b1, 1'b0);
    strobe(201, 200, 1'b1, 1'b0);
    strobe(202, 200, 1'b1, 1'b0);
    strobe(203, 200, 1'b1, 1'b0);
    apply_reset();
    fs_only();

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
